link_tx_arbiter: RTL

Transmit-side controller for the two-flop, four-phase req/ack link. Shares one outgoing link (`req`, `data_tx`, `ack`) among `NUM_SRC` local sources with round-robin arbitration. Latches the winning source's word, then sequences the full four-phase handshake against the asynchronous `ack` from the receiving core. Sits in the sending core, directly opposite the link receiver.

---
 rtl/link_tx_arbiter_if.sv | 23 ++
 rtl/link_tx_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/link_tx_arbiter_if.sv
// Source-side and link-side handshake bundle for the link transmit arbiter.
// The master modport is taken by the arbiter; the slave modport is taken by the sources and the remote model.
interface link_tx_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SRC    = 4
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ack;
    logic                          req;
    logic [DATA_WIDTH-1:0]         data_tx;
    logic                          ack;

    modport master (
        input  src_valid, src_data, ack,
        output src_ack, req, data_tx
    );

    modport slave (
        output src_valid, src_data, ack,
        input  src_ack, req, data_tx
    );
endinterface

// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter and four-phase req/ack transmitter for one shared outgoing link.
// The asynchronous ack is double-flopped; the FSM only looks at the synchronised copy.
module link_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SRC_W      = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    link_tx_arbiter_if.master   lnk,
    output logic                busy,
    output logic [SRC_W-1:0]    cur_src,
    output logic                xfer_done
);

    localparam int unsigned SRC_LAST = NUM_SRC - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_REQ_HI = 2'b10,
        S_REQ_LO = 2'b11
    } state_t;

    state_t                  state;
    logic                    ack_meta;
    logic                    ack_s;
    logic [SRC_W-1:0]        rr_ptr;
    logic                    req_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [NUM_SRC-1:0]      src_ack_q;

    logic                    found_c;
    logic [SRC_W-1:0]        win_c;
    logic [DATA_WIDTH-1:0]   win_data_c;
    logic [SRC_W-1:0]        next_ptr_c;

    // First valid source at or above rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        int unsigned idx;
        found_c    = 1'b0;
        win_c      = '0;
        win_data_c = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_SRC;
            if (!found_c && lnk.src_valid[SRC_W'(idx)]) begin
                found_c    = 1'b1;
                win_c      = SRC_W'(idx);
                win_data_c = lnk.src_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign next_ptr_c = (cur_src == SRC_W'(SRC_LAST)) ? '0 : cur_src + SRC_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ack_meta  <= 1'b0;
            ack_s     <= 1'b0;
            rr_ptr    <= '0;
            req_q     <= 1'b0;
            data_q    <= '0;
            src_ack_q <= '0;
            busy      <= 1'b0;
            cur_src   <= '0;
            xfer_done <= 1'b0;
        end else begin
            ack_meta  <= lnk.ack;
            ack_s     <= ack_meta;
            src_ack_q <= '0;
            xfer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A stale high ack_s blocks launch until the remote side has released.
                    if (enable && !ack_s && found_c) begin
                        data_q    <= win_data_c;
                        cur_src   <= win_c;
                        src_ack_q <= NUM_SRC'(1) << win_c;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    req_q <= 1'b1;
                    state <= S_REQ_HI;
                end
                S_REQ_HI: begin
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= S_REQ_LO;
                    end
                end
                S_REQ_LO: begin
                    if (!ack_s) begin
                        xfer_done <= 1'b1;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr_c;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign lnk.req     = req_q;
    assign lnk.data_tx = data_q;
    assign lnk.src_ack = src_ack_q;

endmodule
